// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch control path.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_WIDTH = 8;
  localparam int unsigned FETCH_DATA_WIDTH = 32;

  // Opcode field position inside an instruction word
  localparam int unsigned OPCODE_MSB   = 31;
  localparam int unsigned OPCODE_LSB   = 26;
  localparam int unsigned OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

  localparam logic [OPCODE_WIDTH-1:0] HALT_OPCODE_DEFAULT = 6'h3F;

  // Fetch controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry queue holding fetched {pc, instruction} pairs.
// Slot 0 is always the head; entries shift forward on pop.
module fetch_skid_fifo #(
  parameter int unsigned WIDTH = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [1:0]       count,
  output logic [WIDTH-1:0] head
);

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]       count_q, count_d;

  // Next-state for storage and occupancy; flush overrides push/pop
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) slot0_d = din;
          else                 slot1_d = din;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          slot0_d = slot1_q;
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; a full queue shifts and refills the tail
          if (count_q == 2'd2) begin
            slot0_d = slot1_q;
            slot1_d = din;
          end else begin
            slot0_d = din;
          end
        end
        default: ;
      endcase
    end
  end

  // Queue registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= '0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot0_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the combinational
// ROM, queues fetched words for decode, and handles redirect and HALT.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int unsigned              ADDR_WIDTH  = FETCH_ADDR_WIDTH,
  parameter int unsigned              DATA_WIDTH  = FETCH_DATA_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]    RESET_PC    = '0,
  parameter logic [OPCODE_WIDTH-1:0]  HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_data,
  input  logic                  redirect_en,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  input  logic                  resume,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic                  halted
);

  localparam int unsigned ENTRY_W = ADDR_WIDTH + DATA_WIDTH;

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;

  logic [1:0]            count;
  logic [ENTRY_W-1:0]    head;
  logic                  push;
  logic                  pop;
  logic                  flush;
  logic                  halt_word;

  assign out_valid = (count != 2'd0);
  assign pop       = out_valid && out_ready;
  assign halt_word = (rom_data[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE);

  // Next state, PC and queue control; redirect outranks everything
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    flush   = 1'b0;
    if (redirect_en) begin
      flush   = 1'b1;
      pc_d    = redirect_addr;
      state_d = ST_FETCH;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_FETCH;
        ST_FETCH: begin
          // a full queue still accepts when decode drains the head this cycle
          if ((count != 2'd2) || pop) begin
            push = 1'b1;
            pc_d = pc_q + 1'b1;
            if (halt_word) state_d = ST_HALT;
          end
        end
        ST_HALT: begin
          if (resume) state_d = ST_FETCH;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and PC registers, cleared asynchronously
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_skid_fifo #(
    .WIDTH(ENTRY_W)
  ) u_queue (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ({pc_q, rom_data}),
    .count (count),
    .head  (head)
  );

  assign rom_addr  = pc_q;
  assign out_pc    = head[ENTRY_W-1:DATA_WIDTH];
  assign out_instr = head[DATA_WIDTH-1:0];
  assign halted    = (state_q == ST_HALT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed table, corner sequences, random run
// against a queue-based reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  rom_addr;
  logic [31:0] rom_data;
  logic        redirect_en = 1'b0;
  logic [7:0]  redirect_addr = '0;
  logic        resume = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;

  logic [31:0] rom [256];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  fetch_sequencer #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .RESET_PC   (8'h00),
    .HALT_OPCODE(6'h3F)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .redirect_en  (redirect_en),
    .redirect_addr(redirect_addr),
    .resume       (resume),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .halted       (halted)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [7:0]  pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];
  int   m_pc;
  bit   m_started;
  bit   m_halted;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_pc      = 0;
    m_started = 0;
    m_halted  = 0;
  endtask

  // One clock edge of the specified behaviour, evaluated on pre-edge values
  task automatic model_edge(input bit redir, input int tgt, input bit res, input bit rdy);
    ent_t e;
    if (mq.size() > 0 && rdy) e = mq.pop_front();
    if (redir) begin
      mq.delete();
      m_pc      = tgt;
      m_halted  = 0;
      m_started = 1;
    end else if (!m_started) begin
      m_started = 1;
    end else if (!m_halted) begin
      if (mq.size() < 2) begin
        e.pc    = m_pc[7:0];
        e.instr = rom[m_pc];
        mq.push_back(e);
        if (rom[m_pc][31:26] == 6'h3F) m_halted = 1;
        m_pc = (m_pc + 1) % 256;
      end
    end else if (res) begin
      m_halted = 0;
    end
  endtask

  task automatic check_model();
    chk("valid", {31'd0, out_valid}, {31'd0, mq.size() != 0});
    chk("rom_addr", {24'd0, rom_addr}, m_pc);
    chk("halted", {31'd0, halted}, {31'd0, m_halted});
    if (mq.size() != 0) begin
      chk("out_pc", {24'd0, out_pc}, {24'd0, mq[0].pc});
      chk("out_instr", out_instr, mq[0].instr);
    end
  endtask

  task automatic step(input bit redir, input logic [7:0] tgt, input bit res, input bit rdy);
    redirect_en   = redir;
    redirect_addr = tgt;
    resume        = res;
    out_ready     = rdy;
    model_edge(redir, int'(tgt), res, rdy);
    @(posedge clk);
    #1;
    check_model();
  endtask

  // Reset pulse between edges; outputs must clear without any clock edge
  task automatic apply_reset();
    @(negedge clk);
    reset       = 1'b0;
    redirect_en = 1'b0;
    resume      = 1'b0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_rom_addr", {24'd0, rom_addr}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    bit         rst;
    bit         ready;
    bit         exp_valid;
    logic [7:0] exp_pc;
    logic [7:0] exp_addr;
  } vec_t;

  vec_t tbl[14];

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {6'(i % 62), 26'(i * 977 + 13)};

    // start-up with decode always ready
    tbl[0]  = '{1, 1, 0, 8'h00, 8'h00};
    tbl[1]  = '{0, 1, 1, 8'h00, 8'h01};
    tbl[2]  = '{0, 1, 1, 8'h01, 8'h02};
    tbl[3]  = '{0, 1, 1, 8'h02, 8'h03};
    tbl[4]  = '{0, 1, 1, 8'h03, 8'h04};
    // back-pressure for 5 edges, then release
    tbl[5]  = '{1, 0, 0, 8'h00, 8'h00};
    tbl[6]  = '{0, 0, 1, 8'h00, 8'h01};
    tbl[7]  = '{0, 0, 1, 8'h00, 8'h02};
    tbl[8]  = '{0, 0, 1, 8'h00, 8'h02};
    tbl[9]  = '{0, 0, 1, 8'h00, 8'h02};
    tbl[10] = '{0, 1, 1, 8'h01, 8'h03};
    tbl[11] = '{0, 1, 1, 8'h02, 8'h04};
    tbl[12] = '{0, 1, 1, 8'h03, 8'h05};
    tbl[13] = '{0, 1, 1, 8'h04, 8'h06};

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) apply_reset();
      step(1'b0, 8'h00, 1'b0, tbl[i].ready);
      chk("tbl_valid", {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      chk("tbl_rom_addr", {24'd0, rom_addr}, {24'd0, tbl[i].exp_addr});
      if (tbl[i].exp_valid) begin
        chk("tbl_pc", {24'd0, out_pc}, {24'd0, tbl[i].exp_pc});
        chk("tbl_instr", out_instr, rom[tbl[i].exp_pc]);
      end
    end

    // redirect with a full queue and a same-cycle pop
    apply_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("redir_pre_valid", {31'd0, out_valid}, 32'd1);
    chk("redir_pre_pc", {24'd0, out_pc}, 32'h00);
    step(1'b1, 8'h40, 1'b0, 1'b1);
    chk("redir_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("redir_addr", {24'd0, rom_addr}, 32'h40);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("redir_target_pc", {24'd0, out_pc}, 32'h40);

    // HALT word at address 5, then resume
    rom[5][31:26] = 6'h3F;
    apply_reset();
    for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("halt_word_pc", {24'd0, out_pc}, 32'h05);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_addr", {24'd0, rom_addr}, 32'h06);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("halt_no_push", {31'd0, out_valid}, 32'd0);
    chk("halt_addr_hold", {24'd0, rom_addr}, 32'h06);
    step(1'b0, 8'h00, 1'b1, 1'b1);
    chk("resume_halted", {31'd0, halted}, 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("resume_pc", {24'd0, out_pc}, 32'h06);
    rom[5] = {6'(5), 26'(5 * 977 + 13)};

    // PC wrap from 8'hFF
    step(1'b1, 8'hFE, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("wrap_pc", {24'd0, out_pc}, 32'hFF);
    chk("wrap_addr", {24'd0, rom_addr}, 32'h00);

    // redirect (with resume) while halted
    rom[8'h21][31:26] = 6'h3F;
    step(1'b1, 8'h20, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("hredir_halted", {31'd0, halted}, 32'd1);
    step(1'b1, 8'h80, 1'b1, 1'b1);
    chk("hredir_clear", {31'd0, halted}, 32'd0);
    chk("hredir_addr", {24'd0, rom_addr}, 32'h80);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    chk("hredir_pc", {24'd0, out_pc}, 32'h80);

    // asynchronous reset while halted with a queued word
    step(1'b1, 8'h21, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("mid_halted", {31'd0, halted}, 32'd1);
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    apply_reset();
    rom[8'h21] = {6'(8'h21 % 62), 26'(8'h21 * 977 + 13)};

    // random traffic against the model
    for (int i = 0; i < 256; i++) begin
      rom[i] = $urandom;
      if ($urandom_range(0, 9) == 0) rom[i][31:26] = 6'h3F;
      else if (rom[i][31:26] == 6'h3F) rom[i][31:26] = 6'h00;
    end
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) apply_reset();
      step($urandom_range(0, 19) == 0, 8'($urandom), $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Control block for the instruction-fetch path. It owns the program counter, drives the combinational instruction ROM address, and buffers fetched {pc, instruction} pairs in a 2-entry queue. The queue feeds decode through a valid/ready handshake. It also handles branch redirects (with flush), downstream back-pressure, and a HALT opcode that stops fetching until released.

## Interface
Parameters:
- ADDR_WIDTH, 8: PC / ROM address width.
- DATA_WIDTH, 32: instruction width.
- RESET_PC, 0: PC value loaded at reset.
- HALT_OPCODE, 6'h3F: value of instr[31:26] that halts fetch.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; asserting low clears all state immediately.
- rom_addr  out  ADDR_WIDTH  address to instruction ROM; equals internal PC register.
- rom_data  in  DATA_WIDTH  ROM word for rom_addr, valid in the same cycle (combinational ROM).
- redirect_en  in  1  branch redirect request, sampled each edge.
- redirect_addr  in  ADDR_WIDTH  redirect target.
- resume  in  1  leave HALT state.
- out_valid  out  1  head of queue is valid.
- out_ready  in  1  decode accepts head this cycle.
- out_instr  out  DATA_WIDTH  head instruction.
- out_pc  out  ADDR_WIDTH  address of head instruction.
- halted  out  1  high while in HALT.

## Operation
- States:
  - IDLE: reset state, no fetch.
  - FETCH: fetching.
  - HALT: no fetch; the queue still drains.
- State transitions:
  - IDLE → FETCH unconditionally on the first edge after reset release.
  - FETCH → HALT when a pushed word has opcode == HALT_OPCODE.
  - HALT → FETCH on resume.
  - Any state → FETCH on redirect_en.
- Pop: when out_valid && out_ready, the head is consumed.
- Push condition in FETCH, no redirect: count < 2, or count == 2 with a pop this cycle.
- Push action: {rom_addr, rom_data} enters the tail, and PC ← PC+1 modulo 2^ADDR_WIDTH (8'hFF wraps to 8'h00).
- No push: PC holds.
- HALT word handling: the HALT word itself is pushed and delivered. PC advances past it (to halt address+1). Fetch resumes from that PC after resume.
- Redirect has highest priority:
  - Queue is flushed (count ← 0) and PC ← redirect_addr.
  - State ← FETCH; no push that edge.
  - A pop in the same cycle still counts as accepted by decode; the remaining entries are discarded.
- Redirect in HALT also clears halt. resume together with redirect has the same effect as redirect alone.
- resume in FETCH or IDLE is ignored.
- out_valid = (count != 0). out_instr and out_pc show the head; their values are don't-care when out_valid is 0.
- Queue count width is 2 bits; legal values are 0..2.
- halted = (state == HALT), registered-state decode.

## Timing
- Reset values: PC = RESET_PC (so rom_addr = RESET_PC), count 0, out_valid 0, halted 0, state IDLE. All are asynchronous on reset low.
- Reset asserted mid-operation discards queue contents and PC immediately.
- Start-up, counting edges after reset release:
  - Edge 1: IDLE → FETCH.
  - Edge 2: pushes the RESET_PC word; out_valid is high after edge 2.
- Throughput: with out_ready held high, one instruction per cycle with no bubbles. Queue occupancy stays at 1.
- Back-pressure: with out_ready low, the queue fills after 2 pushes and PC freezes. Fetch restarts on the same edge as the first pop.
- Redirect latency:
  - redirect_en sampled at edge N: out_valid is low after N.
  - The target word is pushed at edge N+1 and visible after N+1.
- Halt latency: halted rises on the edge that pushes the HALT word. Resume sampled at edge M: the next word is pushed at edge M+1.

## Structure
- Shared package (fetch_pkg): ADDR_WIDTH/DATA_WIDTH defaults, opcode field position [31:26], HALT_OPCODE, and the state encoding (IDLE=0, FETCH=1, HALT=2).
- One sub-module: fetch_skid_fifo, a 2-entry queue.
  - Width ADDR_WIDTH+DATA_WIDTH.
  - Controls: push, pop, flush.
  - Outputs: count, head.
  - Simultaneous push+pop allowed when full.
- The FSM and PC live in fetch_sequencer.

## Test plan
- Reset release with ROM[0..3]=A,B,C,D and out_ready=1 → out_valid rises after edge 2; outputs are (0,A),(1,B),(2,C),(3,D) on consecutive cycles.
- out_ready=0 for 5 cycles after start → count saturates at 2 holding PC 0,1 and rom_addr frozen at 2. Raising out_ready → delivers 0,1,2 with no gaps or duplicates.
- Redirect to 8'h40 while the queue holds 2 entries, with a pop in the same cycle → the popped entry is delivered, the other is discarded, and the next delivered pc is 8'h40.
- ROM[5] opcode 6'h3F → word 5 is delivered, halted=1, rom_addr=6, no further pushes. resume pulse → next delivered pc=6.
- PC at 8'hFF → next fetch address is 8'h00. Redirect while halted → halted clears and fetch proceeds from the target.
- reset pulsed low mid-stream → out_valid=0, rom_addr=RESET_PC, halted=0 immediately, without waiting for a clock edge.
